blake3_round_scheduler: RTL

Sequences one shared, fully pipelined BLAKE3 G-mixing unit through a complete 7-round compression. It owns the 16-word state and message registers and issues four column G calls, then four diagonal G calls, per round, permuting the message between rounds. It folds the final state into a 256-bit chaining value. It sits between the nonce/header feeder and the difficulty comparator in the miner core; the G unit is instantiated beside it in the core wrapper.

---
 rtl/blake3_round_scheduler_pkg.sv | 73 +++++++
 rtl/blake3_round_scheduler_if.sv | 17 +
 rtl/blake3_round_scheduler_msg_perm.sv | 13 +
 rtl/blake3_round_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/blake3_round_scheduler_pkg.sv
// Shared constants, types and helpers for the BLAKE3 round scheduler slice.
package blake3_pkg;

  localparam int G_LATENCY_DEF = 4;
  localparam int C_DELAY_DEF   = 1;
  localparam int Y_DELAY_DEF   = 2;
  localparam int NUM_ROUNDS    = 7;

  // Domain flags carried in state word 15.
  localparam logic [31:0] CHUNK_START = 32'h0000_0001;
  localparam logic [31:0] CHUNK_END   = 32'h0000_0002;
  localparam logic [31:0] PARENT      = 32'h0000_0004;
  localparam logic [31:0] ROOT        = 32'h0000_0008;

  typedef logic [31:0] word_t;
  // Word i sits at bits [32i+31:32i], matching the flat bus ordering.
  typedef word_t [15:0] block_t;

  localparam word_t IV [0:7] = '{
    32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
    32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19
  };

  localparam int MSG_PERM [0:15] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINAL} state_t;

  // State-word indices touched by one G call.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
  } g_idx_t;

  // Tag riding alongside an in-flight G call so its result lands in the right words.
  typedef struct packed {
    logic       valid;
    logic       diag;
    logic [1:0] slot;
  } tag_t;

  // One stage of an operand skew delay line.
  typedef struct packed {
    logic  valid;
    word_t data;
  } opnd_t;

  // Column slot s: (s, 4+s, 8+s, 12+s). Diagonal slot s rotates each row by its row number;
  // the 2-bit adds wrap mod 4 by construction.
  function automatic g_idx_t g_indices(input logic [1:0] slot, input logic diag);
    g_idx_t r;
    r.a = {2'b00, slot};
    if (diag) begin
      r.b = {2'b01, slot + 2'd1};
      r.c = {2'b10, slot + 2'd2};
      r.d = {2'b11, slot + 2'd3};
    end else begin
      r.b = {2'b01, slot};
      r.c = {2'b10, slot};
      r.d = {2'b11, slot};
    end
    return r;
  endfunction

  // Chaining value: out[i] = v[i] ^ v[i+8].
  function automatic logic [255:0] fold_hash(input block_t v);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = v[i] ^ v[i+8];
    return r;
  endfunction

endpackage

// File: rtl/blake3_round_scheduler_if.sv
// Operand/result bus between the round scheduler (master) and the shared G unit (slave).
interface blake3_round_scheduler_if;
  import blake3_pkg::*;

  word_t G_A_O, G_B_O, G_C_O, G_D_O, G_X_O, G_Y_O;
  word_t G_A_I, G_B_I, G_C_I, G_D_I;

  modport master (
    output G_A_O, G_B_O, G_C_O, G_D_O, G_X_O, G_Y_O,
    input  G_A_I, G_B_I, G_C_I, G_D_I
  );

  modport slave (
    input  G_A_O, G_B_O, G_C_O, G_D_O, G_X_O, G_Y_O,
    output G_A_I, G_B_I, G_C_I, G_D_I
  );
endinterface

// File: rtl/blake3_round_scheduler_msg_perm.sv
// Combinational BLAKE3 message word permutation applied between rounds.
module blake3_msg_perm
  import blake3_pkg::*;
(
  input  block_t m_in,
  output block_t m_out
);

  for (genvar i = 0; i < 16; i++) begin : g_perm
    assign m_out[i] = m_in[MSG_PERM[i]];
  end

endmodule

// File: rtl/blake3_round_scheduler.sv
// Drives one shared pipelined G unit through a full 7-round BLAKE3 compression:
// four column calls then four diagonal calls per round, results written back by slot tag.
module blake3_round_scheduler
  import blake3_pkg::*;
#(
  parameter int G_LATENCY = G_LATENCY_DEF,
  parameter int C_DELAY   = C_DELAY_DEF,
  parameter int Y_DELAY   = Y_DELAY_DEF
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start_I,
  input  logic [255:0] Cv_I,
  input  logic [511:0] Msg_I,
  input  logic [63:0]  Counter_I,
  input  logic [31:0]  BlockLen_I,
  input  logic [31:0]  Flags_I,
  output logic         Ready_O,
  output logic         Done_O,
  output logic [255:0] Hash_O,
  blake3_round_scheduler_if.master g_bus
);

  localparam logic [2:0] LAST_ROUND = 3'(NUM_ROUNDS - 1);

  state_t       state_q, state_d;
  logic [1:0]   slot_q, slot_d;
  logic         diag_q, diag_d;
  logic [2:0]   round_q, round_d;
  block_t       v_q, m_q, v_init, m_perm;
  logic [255:0] hash_q;

  tag_t  tag_pipe [G_LATENCY];
  opnd_t c_pipe   [C_DELAY];
  opnd_t y_pipe   [Y_DELAY];

  logic   load_job, issue_en, perm_en, hash_en, last_result;
  tag_t   tag_out;
  g_idx_t iss_idx, wr_idx;
  logic [3:0] x_idx, y_idx;

  blake3_msg_perm u_msg_perm (
    .m_in  (m_q),
    .m_out (m_perm)
  );

  assign iss_idx     = g_indices(slot_q, diag_q);
  assign x_idx       = {diag_q, slot_q, 1'b0};
  assign y_idx       = {diag_q, slot_q, 1'b1};
  assign tag_out     = tag_pipe[G_LATENCY-1];
  assign wr_idx      = g_indices(tag_out.slot, tag_out.diag);
  assign last_result = tag_out.valid && (tag_out.slot == 2'd3);

  // Initial compression state assembled from the job inputs.
  always_comb begin
    for (int i = 0; i < 8; i++) v_init[i] = Cv_I[32*i +: 32];
    for (int i = 0; i < 4; i++) v_init[8+i] = IV[i];
    v_init[12] = Counter_I[31:0];
    v_init[13] = Counter_I[63:32];
    v_init[14] = BlockLen_I;
    v_init[15] = Flags_I;
  end

  // Next-state and control decode: issue four slots, drain, advance half/round, fold.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    slot_d   = slot_q;
    diag_d   = diag_q;
    round_d  = round_q;
    load_job = 1'b0;
    issue_en = 1'b0;
    perm_en  = 1'b0;
    hash_en  = 1'b0;
    Ready_O  = 1'b0;
    Done_O   = 1'b0;

    unique case (state_q)
      IDLE: Ready_O = 1'b1;
      ISSUE: begin
        issue_en = 1'b1;
        slot_d   = slot_q + 2'd1;
        if (slot_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_result) begin
          if (!diag_q) begin
            diag_d  = 1'b1;
            state_d = ISSUE;
          end else if (round_q < LAST_ROUND) begin
            perm_en = 1'b1;
            round_d = round_q + 3'd1;
            diag_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            state_d = FINAL;
          end
        end
      end
      FINAL: begin
        Ready_O = 1'b1;
        Done_O  = 1'b1;
        hash_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accepting in FINAL as well as IDLE gives back-to-back jobs with no idle cycle.
    if (Ready_O && Start_I) begin
      load_job = 1'b1;
      state_d  = ISSUE;
      slot_d   = '0;
      diag_d   = 1'b0;
      round_d  = '0;
    end
  end

  // FSM state and sequencing counters.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      diag_q  <= 1'b0;
      round_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
      slot_q  <= slot_d;
      diag_q  <= diag_d;
      round_q <= round_d;
    end
  end

  // Working state, message words and held chaining value.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      // NOTE: v/m are flop arrays, not RAM, so they can and do reset to a known zero state.
      v_q    <= '0;
      m_q    <= '0;
      hash_q <= '0;
    end else begin
      if (load_job) begin
        v_q <= v_init;
        m_q <= block_t'(Msg_I);
      end else begin
        if (tag_out.valid) begin
          v_q[wr_idx.a] <= g_bus.G_A_I;
          v_q[wr_idx.b] <= g_bus.G_B_I;
          v_q[wr_idx.c] <= g_bus.G_C_I;
          v_q[wr_idx.d] <= g_bus.G_D_I;
        end
        if (perm_en) m_q <= m_perm;
      end
      if (hash_en) hash_q <= fold_hash(v_q);
    end
  end

  // Slot-tag pipeline and the delayed C/Y operand lines, all captured at issue time.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < G_LATENCY; k++) tag_pipe[k] <= '0;
      for (int k = 0; k < C_DELAY; k++)   c_pipe[k]   <= '0;
      for (int k = 0; k < Y_DELAY; k++)   y_pipe[k]   <= '0;
    end else begin
      tag_pipe[0] <= '{valid: issue_en, diag: diag_q, slot: slot_q};
      for (int k = 1; k < G_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
      c_pipe[0] <= '{valid: issue_en, data: issue_en ? v_q[iss_idx.c] : '0};
      for (int k = 1; k < C_DELAY; k++) c_pipe[k] <= c_pipe[k-1];
      y_pipe[0] <= '{valid: issue_en, data: issue_en ? m_q[y_idx] : '0};
      for (int k = 1; k < Y_DELAY; k++) y_pipe[k] <= y_pipe[k-1];
    end
  end

  // Operands are zero whenever nothing is due on that lane.
  assign g_bus.G_A_O = issue_en ? v_q[iss_idx.a] : '0;
  assign g_bus.G_B_O = issue_en ? v_q[iss_idx.b] : '0;
  assign g_bus.G_D_O = issue_en ? v_q[iss_idx.d] : '0;
  assign g_bus.G_X_O = issue_en ? m_q[x_idx]     : '0;
  assign g_bus.G_C_O = c_pipe[C_DELAY-1].valid ? c_pipe[C_DELAY-1].data : '0;
  assign g_bus.G_Y_O = y_pipe[Y_DELAY-1].valid ? y_pipe[Y_DELAY-1].data : '0;

  // The fold is combinational in FINAL so Hash_O is valid alongside the Done_O pulse.
  assign Hash_O = (state_q == FINAL) ? fold_hash(v_q) : hash_q;

endmodule
